// File: rtl/quire_seq_ctrl_if.sv
// Handshake and data bundle for quire_seq_ctrl: job config, product stream,
// quire input/output links, result port and stall counter.
interface quire_seq_ctrl_if #(
  parameter int FRAC_W  = 8,
  parameter int SCALE_W = 6,
  parameter int QUIRE_W = 64,
  parameter int LEN_W   = 16,
  parameter int NVEC_W  = 16
) ();
  logic               cfg_start_i;
  logic [LEN_W-1:0]   cfg_len_i;
  logic [NVEC_W-1:0]  cfg_nvec_i;
  logic               busy_o;
  logic               done_o;
  logic               in_rts_i;
  logic               in_rtr_o;
  logic [FRAC_W-1:0]  in_fraction_i;
  logic [SCALE_W-1:0] in_scale_i;
  logic               in_sign_i;
  logic               in_zero_i;
  logic               in_NaR_i;
  logic               q_rts_o;
  logic               q_rtr_i;
  logic               q_sow_o;
  logic               q_eow_o;
  logic [FRAC_W-1:0]  q_fraction_o;
  logic [SCALE_W-1:0] q_scale_o;
  logic               q_sign_o;
  logic               q_zero_o;
  logic               q_NaR_o;
  logic               q_rts_i;
  logic               q_rtr_o;
  logic               q_eow_i;
  logic [QUIRE_W-1:0] q_data_i;
  logic               q_NaR_i;
  logic               res_rts_o;
  logic               res_rtr_i;
  logic [QUIRE_W-1:0] res_data_o;
  logic               res_NaR_o;
  logic [NVEC_W-1:0]  res_idx_o;
  logic [31:0]        perf_stall_o;

  modport master (
    output cfg_start_i, cfg_len_i, cfg_nvec_i,
    output in_rts_i, in_fraction_i, in_scale_i, in_sign_i, in_zero_i, in_NaR_i,
    output q_rtr_i, q_rts_i, q_eow_i, q_data_i, q_NaR_i, res_rtr_i,
    input  busy_o, done_o, in_rtr_o,
    input  q_rts_o, q_sow_o, q_eow_o, q_fraction_o, q_scale_o, q_sign_o, q_zero_o, q_NaR_o,
    input  q_rtr_o, res_rts_o, res_data_o, res_NaR_o, res_idx_o, perf_stall_o
  );

  modport slave (
    input  cfg_start_i, cfg_len_i, cfg_nvec_i,
    input  in_rts_i, in_fraction_i, in_scale_i, in_sign_i, in_zero_i, in_NaR_i,
    input  q_rtr_i, q_rts_i, q_eow_i, q_data_i, q_NaR_i, res_rtr_i,
    output busy_o, done_o, in_rtr_o,
    output q_rts_o, q_sow_o, q_eow_o, q_fraction_o, q_scale_o, q_sign_o, q_zero_o, q_NaR_o,
    output q_rtr_o, res_rts_o, res_data_o, res_NaR_o, res_idx_o, perf_stall_o
  );
endinterface

// File: rtl/quire_seq_ctrl.sv
// Frames an unframed product stream into len-beat windows for one quire and keeps
// only each window's eow result. Optional stall counter: QUIRE_SEQ_PERF_STALL_EN.
module quire_seq_ctrl #(
  parameter int FRAC_W  = 8,
  parameter int SCALE_W = 6,
  parameter int QUIRE_W = 64,
  parameter int LEN_W   = 16,
  parameter int NVEC_W  = 16
) (
  input logic            clk,
  input logic            rst,
  quire_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    len_reg, beat_cnt_reg;
  logic [NVEC_W-1:0]   nvec_reg, sent_cnt_reg, recv_cnt_reg;
  logic                res_valid_reg, res_nar_reg, done_reg;
  logic [QUIRE_W-1:0]  res_data_reg;
  logic [NVEC_W-1:0]   res_idx_reg;

  logic run, sow, eow, start_acc, done_next;
  logic beat_xfer, q_rtr, res_load, res_drain;

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    start_acc  = 1'b0;
    run        = 1'b0;
    sow        = 1'b0;
    eow        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cfg_start_i) begin
          start_acc = 1'b1;
          // A degenerate job completes immediately without touching the quire
          if (bus.cfg_len_i != '0 && bus.cfg_nvec_i != '0) state_next = RUN;
          else                                             done_next  = 1'b1;
        end
      end
      RUN: begin
        run = 1'b1;
        sow = (beat_cnt_reg == '0);
        eow = (beat_cnt_reg == len_reg - LEN_W'(1));
        if (bus.in_rts_i && bus.q_rtr_i && eow && sent_cnt_reg == nvec_reg - NVEC_W'(1))
          state_next = FLUSH;
      end
      FLUSH: begin
        if (recv_cnt_reg == nvec_reg && !res_valid_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign beat_xfer = run & bus.in_rts_i & bus.q_rtr_i;
  // Non-eow quire beats are always swallowed; eow beats wait for result space
  assign q_rtr     = (state_reg != IDLE) &
                     (~bus.q_eow_i | ~res_valid_reg | (res_valid_reg & bus.res_rtr_i));
  assign res_load  = bus.q_rts_i & q_rtr & bus.q_eow_i;
  assign res_drain = res_valid_reg & bus.res_rtr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      nvec_reg      <= '0;
      beat_cnt_reg  <= '0;
      sent_cnt_reg  <= '0;
      recv_cnt_reg  <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_nar_reg   <= 1'b0;
      res_idx_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      if (start_acc) begin
        len_reg      <= bus.cfg_len_i;
        nvec_reg     <= bus.cfg_nvec_i;
        beat_cnt_reg <= '0;
        sent_cnt_reg <= '0;
        recv_cnt_reg <= '0;
      end else begin
        if (beat_xfer) begin
          if (eow) begin
            beat_cnt_reg <= '0;
            sent_cnt_reg <= sent_cnt_reg + NVEC_W'(1);
          end else begin
            beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
          end
        end
        if (res_load) recv_cnt_reg <= recv_cnt_reg + NVEC_W'(1);
      end
      if (res_load) begin
        res_valid_reg <= 1'b1;
        res_data_reg  <= bus.q_data_i;
        res_nar_reg   <= bus.q_NaR_i;
        res_idx_reg   <= recv_cnt_reg;
      end else if (res_drain) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.busy_o       = (state_reg != IDLE);
  assign bus.done_o       = done_reg;
  assign bus.in_rtr_o     = run & bus.q_rtr_i;
  assign bus.q_rts_o      = run & bus.in_rts_i;
  assign bus.q_sow_o      = sow;
  assign bus.q_eow_o      = eow;
  assign bus.q_fraction_o = run ? bus.in_fraction_i : {FRAC_W{1'b0}};
  assign bus.q_scale_o    = run ? bus.in_scale_i : {SCALE_W{1'b0}};
  assign bus.q_sign_o     = run & bus.in_sign_i;
  assign bus.q_zero_o     = run & bus.in_zero_i;
  assign bus.q_NaR_o      = run & bus.in_NaR_i;
  assign bus.q_rtr_o      = q_rtr;
  assign bus.res_rts_o    = res_valid_reg;
  assign bus.res_data_o   = res_data_reg;
  assign bus.res_NaR_o    = res_nar_reg;
  assign bus.res_idx_o    = res_idx_reg;

`ifdef QUIRE_SEQ_PERF_STALL_EN
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_reg <= '0;
    end else if (start_acc) begin
      perf_stall_reg <= '0;
    end else if (run && bus.in_rts_i && !bus.q_rtr_i && perf_stall_reg != 32'hFFFF_FFFF) begin
      perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign bus.perf_stall_o = perf_stall_reg;
`else
  assign bus.perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_quire_seq_ctrl.sv
// Directed + randomized bench for quire_seq_ctrl with a 2-cycle quire model and
// a vector-level reference built directly from the generated product stream.
module tb_quire_seq_ctrl;
  localparam int FRAC_W = 8, SCALE_W = 6, QUIRE_W = 64, LEN_W = 16, NVEC_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quire_seq_ctrl_if #(.FRAC_W(FRAC_W), .SCALE_W(SCALE_W), .QUIRE_W(QUIRE_W),
                      .LEN_W(LEN_W), .NVEC_W(NVEC_W)) bus ();

  quire_seq_ctrl #(.FRAC_W(FRAC_W), .SCALE_W(SCALE_W), .QUIRE_W(QUIRE_W),
                   .LEN_W(LEN_W), .NVEC_W(NVEC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] frac;
    logic [5:0] scale;
    logic       sign;
    logic       zero;
    logic       nar;
  } beat_t;

  typedef struct packed {
    logic [31:0] t;
    logic        eow;
    logic [63:0] data;
    logic        nar;
  } qout_t;

  typedef struct packed {
    logic [63:0] data;
    logic        nar;
    logic [15:0] idx;
  } res_t;

  beat_t in_q[$];
  qout_t qp[$];
  res_t  exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int job_len, job_nvec, mode;
  int beats_seen, done_cnt, done_cyc, start_cyc, last_res_cyc, drops, hold_left, stall_left;
  bit held, degenerate, perf_arm, perf_check_now;
  logic [63:0] acc_m;
  logic        nar_m;

`ifdef QUIRE_SEQ_PERF_STALL_EN
  localparam logic [63:0] PERF_EXP = 64'd7;
`else
  localparam logic [63:0] PERF_EXP = 64'd0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Test-side quire arithmetic: each product is the signed {fraction,scale} magnitude
  function automatic logic [63:0] term(input logic [7:0] f, input logic [5:0] s,
                                       input logic sg, input logic z);
    logic [63:0] mag;
    mag = {50'd0, f, s};
    if (z) return 64'd0;
    return sg ? (64'd0 - mag) : mag;
  endfunction

  task automatic drive();
    perf_check_now = perf_arm;
    perf_arm = 1'b0;
    bus.cfg_start_i = (mode == 1 && bus.busy_o) ? ($urandom_range(0, 7) == 0) : 1'b0;
    bus.cfg_len_i   = 16'($urandom);
    bus.cfg_nvec_i  = 16'($urandom);
    if (in_q.size() > 0) begin
      bus.in_rts_i      = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_fraction_i = in_q[0].frac;
      bus.in_scale_i    = in_q[0].scale;
      bus.in_sign_i     = in_q[0].sign;
      bus.in_zero_i     = in_q[0].zero;
      bus.in_NaR_i      = in_q[0].nar;
    end else begin
      bus.in_rts_i      = degenerate;
      bus.in_fraction_i = 8'($urandom);
      bus.in_scale_i    = 6'($urandom);
      bus.in_sign_i     = 1'($urandom);
      bus.in_zero_i     = 1'b0;
      bus.in_NaR_i      = 1'b0;
    end
    if (stall_left > 0) begin
      bus.in_rts_i = 1'b1;
      bus.q_rtr_i  = 1'b0;
      stall_left--;
      if (stall_left == 0) perf_arm = 1'b1;
    end else begin
      bus.q_rtr_i = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (qp.size() > 0 && int'(qp[0].t) <= cyc) begin
      bus.q_rts_i  = 1'b1;
      bus.q_eow_i  = qp[0].eow;
      bus.q_data_i = qp[0].data;
      bus.q_NaR_i  = qp[0].nar;
    end else begin
      bus.q_rts_i  = 1'b0;
      bus.q_eow_i  = 1'b0;
      bus.q_data_i = 64'd0;
      bus.q_NaR_i  = 1'b0;
    end
    if (mode == 2) begin
      if (!held && bus.res_rts_o) begin
        held = 1'b1;
        hold_left = 10;
      end
      bus.res_rtr_i = (hold_left == 0);
      if (hold_left > 0) hold_left--;
    end else begin
      bus.res_rtr_i = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  endtask

  task automatic observe();
    logic in_x, q_x;
    logic [63:0] tm;
    res_t e;
    in_x = bus.in_rts_i & bus.in_rtr_o;
    q_x  = bus.q_rts_o & bus.q_rtr_i;
    if (in_x || q_x) chk("handshake_pass", 64'(q_x), 64'(in_x));
    if (q_x) begin
      chk("q_sow", 64'(bus.q_sow_o), 64'((beats_seen % job_len) == 0));
      chk("q_eow", 64'(bus.q_eow_o), 64'((beats_seen % job_len) == job_len - 1));
      if (in_q.size() > 0)
        chk("q_fields", 64'({bus.q_fraction_o, bus.q_scale_o, bus.q_sign_o, bus.q_zero_o, bus.q_NaR_o}),
            64'(in_q[0]));
      tm = term(bus.q_fraction_o, bus.q_scale_o, bus.q_sign_o, bus.q_zero_o);
      acc_m = bus.q_sow_o ? tm : acc_m + tm;
      nar_m = bus.q_sow_o ? bus.q_NaR_o : (nar_m | bus.q_NaR_o);
      qp.push_back('{t: 32'(cyc + 2), eow: bus.q_eow_o, data: acc_m, nar: nar_m});
      beats_seen++;
    end
    if (in_x && in_q.size() > 0) void'(in_q.pop_front());
    if (degenerate) begin
      chk("degen_no_q_rts", 64'(bus.q_rts_o), 64'd0);
      chk("degen_busy_low", 64'(bus.busy_o), 64'd0);
    end
    if (bus.q_rts_i) begin
      if (bus.busy_o && !bus.q_eow_i) chk("q_rtr_noneow", 64'(bus.q_rtr_o), 64'd1);
      if (bus.q_rtr_o) void'(qp.pop_front());
      else drops++;
    end
    if (bus.res_rts_o && bus.res_rtr_i) begin
      if (exp_q.size() == 0) begin
        chk("res_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", bus.res_data_o, e.data);
        chk("res_nar", 64'(bus.res_NaR_o), 64'(e.nar));
        chk("res_idx", 64'(bus.res_idx_o), 64'(e.idx));
      end
      last_res_cyc = cyc;
    end
    if (bus.done_o) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", 64'(bus.busy_o), 64'd0);
    end
    if (perf_check_now) begin
      chk("perf_stall", 64'(bus.perf_stall_o), PERF_EXP);
      perf_check_now = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    observe();
    cyc++;
  endtask

  task automatic run_job(input int len, input int nvec, input int md, input int stall, input int abort_at);
    beat_t b;
    logic [63:0] acc;
    logic nar;
    int k;
    job_len = len; job_nvec = nvec; mode = md;
    in_q.delete(); qp.delete(); exp_q.delete();
    beats_seen = 0; done_cnt = 0; drops = 0; held = 0; hold_left = 0;
    stall_left = 0; perf_arm = 0; perf_check_now = 0;
    last_res_cyc = -1; done_cyc = -1;
    degenerate = (len == 0 || nvec == 0);
    if (!degenerate) begin
      for (int v = 0; v < nvec; v++) begin
        acc = 64'd0;
        nar = 1'b0;
        for (int j = 0; j < len; j++) begin
          b.frac  = 8'($urandom);
          b.scale = 6'($urandom);
          b.sign  = 1'($urandom);
          b.zero  = ($urandom_range(0, 7) == 0);
          b.nar   = ($urandom_range(0, 15) == 0);
          in_q.push_back(b);
          acc = acc + term(b.frac, b.scale, b.sign, b.zero);
          nar = nar | b.nar;
        end
        exp_q.push_back('{data: acc, nar: nar, idx: 16'(v)});
      end
    end
    @(negedge clk);
    drive();
    bus.cfg_start_i = 1'b1;
    bus.cfg_len_i   = 16'(len);
    bus.cfg_nvec_i  = 16'(nvec);
    #1;
    observe();
    start_cyc = cyc;
    cyc++;
    stall_left = stall;
    step();
    chk("busy_after_start", 64'(bus.busy_o), 64'(!degenerate));
    for (k = 0; k < 2000; k++) begin
      if (abort_at > 0 && beats_seen >= abort_at) return;
      if (done_cnt > 0 && exp_q.size() == 0) break;
      step();
    end
    $display("job len=%0d nvec=%0d mode=%0d: beats=%0d done_cnt=%0d cycles=%0d",
             len, nvec, md, beats_seen, done_cnt, cyc - start_cyc);
    chk("job_complete", 64'(done_cnt > 0 && exp_q.size() == 0), 64'd1);
    chk("beats_total", 64'(beats_seen), 64'(len * nvec));
    step();
    step();
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("busy_idle_after", 64'(bus.busy_o), 64'd0);
    chk("quire_drained", 64'(qp.size()), 64'd0);
    if (degenerate) chk("done_cycle_degen", 64'(done_cyc), 64'(start_cyc + 1));
    else            chk("done_after_last_res", 64'(done_cyc > last_res_cyc), 64'd1);
    if (md == 2) chk("q_rtr_dropped_on_eow", 64'(drops > 0), 64'd1);
  endtask

  initial begin
    mode = 0; degenerate = 0; stall_left = 0; perf_arm = 0; perf_check_now = 0;
    hold_left = 0; held = 0; job_len = 1; job_nvec = 1;
    bus.cfg_start_i = 0; bus.cfg_len_i = 0; bus.cfg_nvec_i = 0;
    bus.in_rts_i = 0; bus.in_fraction_i = 0; bus.in_scale_i = 0;
    bus.in_sign_i = 0; bus.in_zero_i = 0; bus.in_NaR_i = 0;
    bus.q_rtr_i = 0; bus.q_rts_i = 0; bus.q_eow_i = 0; bus.q_data_i = 0; bus.q_NaR_i = 0;
    bus.res_rtr_i = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_ctrl", 64'({bus.busy_o, bus.done_o, bus.in_rtr_o, bus.q_rts_o, bus.q_sow_o,
                           bus.q_eow_o, bus.q_rtr_o, bus.res_rts_o}), 64'd0);
    chk("reset_res", {bus.res_data_o}, 64'd0);
    chk("reset_perf", 64'(bus.perf_stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_job(4, 2, 0, 0, 0);
    run_job(1, 3, 0, 0, 0);
    run_job(0, 5, 0, 0, 0);
    run_job(3, 2, 2, 0, 0);

    // Abort mid-RUN with two beats already in the current vector
    run_job(4, 2, 0, 0, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", 64'({bus.busy_o, bus.done_o, bus.in_rtr_o, bus.q_rts_o, bus.q_sow_o,
                               bus.q_eow_o, bus.q_rtr_o, bus.res_rts_o}), 64'd0);
    chk("async_rst_perf", 64'(bus.perf_stall_o), 64'd0);
    $display("reset asserted mid-run at cycle %0d", cyc);
    in_q.delete(); qp.delete(); exp_q.delete();
    done_cnt = 0;
    step();
    step();
    chk("no_done_on_abort", 64'(done_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_job(2, 2, 0, 0, 0);
    for (int r = 0; r < 4; r++)
      run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)), 1, 0, 0);
    run_job(4, 1, 0, 7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
